ltl_monitor_seq: RTL and testbench

// Session sequencer for one compiled LTL automaton cluster (STE network + LUT matchers).
// - Accepts a symbol trace over valid/ready.
// - Owns the automaton's run/reset and the first-symbol alignment with start_of_data.
// - Samples the report vector and emits report events, tagged with symbol index, through a small FIFO.
// - Sits between the trace tap and the cluster automaton in each monitor.

---
 rtl/ltl_mon_pkg.sv | 21 ++
 rtl/ltl_mon_evt_fifo.sv | 56 +++++
 rtl/ltl_monitor_seq.sv | 186 ++++++++++++++++++
 tb/tb_ltl_monitor_seq.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ltl_mon_pkg.sv
// Shared types for the LTL monitor session sequencer: FSM states, event record, sample latency.
package ltl_mon_pkg;

  localparam int LTL_MON_NUM_REPORTS = 4;
  localparam int LTL_MON_CNT_W       = 32;
  localparam int LTL_MON_SAMPLE_LAT  = 1;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FLUSH = 3'd1,
    ST_RUN   = 3'd2,
    ST_DRAIN = 3'd3,
    ST_FIN   = 3'd4
  } ltl_mon_state_e;

  typedef struct packed {
    logic [LTL_MON_NUM_REPORTS-1:0] mask;
    logic [LTL_MON_CNT_W-1:0]       index;
  } ltl_mon_evt_t;

endpackage

// File: rtl/ltl_mon_evt_fifo.sv
// Small synchronous FIFO of report events; head data reads as zero while empty.
module ltl_mon_evt_fifo
  import ltl_mon_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  ltl_mon_evt_t             push_data,
  input  logic                     pop,
  output ltl_mon_evt_t             pop_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   free_cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  ltl_mon_evt_t   mem [DEPTH];
  logic [AW-1:0]  wr_ptr_reg;
  logic [AW-1:0]  rd_ptr_reg;
  logic [CW-1:0]  count_reg;
  logic           do_push;
  logic           do_pop;

  assign full     = (count_reg == CW'(DEPTH));
  assign empty    = (count_reg == '0);
  assign free_cnt = CW'(DEPTH) - count_reg;
  // A full FIFO may still accept a push when the head leaves in the same cycle.
  assign do_pop   = pop & ~empty;
  assign do_push  = push & (~full | do_pop);
  assign pop_data = empty ? '0 : mem[rd_ptr_reg];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_reg] <= push_data;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= wr_ptr_reg + AW'(1);
      if (do_pop)  rd_ptr_reg <= rd_ptr_reg + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count_reg <= count_reg + CW'(1);
        2'b01:   count_reg <= count_reg - CW'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end

endmodule

// File: rtl/ltl_monitor_seq.sv
// Session sequencer for one LTL automaton cluster: run/reset control, report sampling, event FIFO.
// Optional first-hit capture ports exist when LTL_MON_FIRST_HIT_EN is defined.
module ltl_monitor_seq
  import ltl_mon_pkg::*;
#(
  parameter int NUM_REPORTS  = LTL_MON_NUM_REPORTS,
  parameter int CNT_W        = LTL_MON_CNT_W,
  parameter int FLUSH_CYCLES = 2,
  parameter int EVT_DEPTH    = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic                   abort,
  input  logic                   sym_valid,
  input  logic [7:0]             sym_data,
  input  logic                   sym_last,
  output logic                   sym_ready,
  output logic                   auto_run,
  output logic                   auto_reset,
  output logic [7:0]             auto_symbols,
  input  logic [NUM_REPORTS-1:0] auto_reports,
  output logic                   evt_valid,
  input  logic                   evt_ready,
  output logic [NUM_REPORTS-1:0] evt_mask,
  output logic [CNT_W-1:0]       evt_index,
  output logic [NUM_REPORTS-1:0] sticky_reports,
`ifdef LTL_MON_FIRST_HIT_EN
  output logic                   first_hit_vld,
  output logic [CNT_W-1:0]       first_hit_idx,
`endif
  output logic                   busy,
  output logic                   done
);

  localparam int FW     = $clog2(FLUSH_CYCLES + 1);
  localparam int FREE_W = $clog2(EVT_DEPTH) + 1;
  localparam int LAT    = LTL_MON_SAMPLE_LAT;
  localparam logic [FW-1:0] FLUSH_LAST = FW'(FLUSH_CYCLES);

  ltl_mon_state_e         state_reg, state_next;
  logic [CNT_W-1:0]       idx_reg;
  logic [FW-1:0]          flush_cnt_reg;
  logic [NUM_REPORTS-1:0] sticky_reg;
  logic                   pend_reg     [LAT];
  logic [CNT_W-1:0]       pend_idx_reg [LAT];

  logic                   flush_done, room, ready_c, beat, start_ok, sample_hit;
  logic                   push, pop, full, empty;
  logic [FREE_W-1:0]      free_cnt;
  ltl_mon_evt_t           push_data, pop_data;

  assign flush_done = (flush_cnt_reg == FLUSH_LAST);
  // Two free slots: one for the sample still in flight, one for this beat's own sample.
  assign room       = (free_cnt >= FREE_W'(2));
  assign start_ok   = (state_reg == ST_IDLE) & start & ~abort;
  assign beat       = sym_valid & ready_c;
  assign sample_hit = pend_reg[LAT-1] & (|auto_reports);

  always_comb begin
    ready_c = 1'b0;
    case (state_reg)
      ST_FLUSH: ready_c = flush_done & room & ~abort;
      ST_RUN:   ready_c = room & ~abort;
      default:  ready_c = 1'b0;
    endcase
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE:  if (start_ok) state_next = ST_FLUSH;
      ST_FLUSH: if (abort) state_next = ST_FIN;
                else if (beat) state_next = sym_last ? ST_DRAIN : ST_RUN;
      ST_RUN:   if (abort) state_next = ST_FIN;
                else if (beat && sym_last) state_next = ST_DRAIN;
      ST_DRAIN: state_next = ST_FIN;
      ST_FIN:   state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg     <= ST_IDLE;
      idx_reg       <= '0;
      flush_cnt_reg <= '0;
      sticky_reg    <= '0;
    end else begin
      state_reg <= state_next;
      if (start_ok) begin
        idx_reg       <= '0;
        flush_cnt_reg <= '0;
        sticky_reg    <= '0;
      end else begin
        if (state_reg == ST_FLUSH && !flush_done) flush_cnt_reg <= flush_cnt_reg + FW'(1);
        if (beat && idx_reg != '1) idx_reg <= idx_reg + CNT_W'(1);
        if (sample_hit) sticky_reg <= sticky_reg | auto_reports;
      end
    end
  end

  // Sample pipeline: the automaton's registered reports line up LAT cycles after the beat.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pend_reg[0]     <= 1'b0;
      pend_idx_reg[0] <= '0;
    end else begin
      pend_reg[0]     <= beat;
      pend_idx_reg[0] <= idx_reg;
    end
  end

  genvar gi;
  for (gi = 1; gi < LAT; gi++) begin : g_lat
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        pend_reg[gi]     <= 1'b0;
        pend_idx_reg[gi] <= '0;
      end else begin
        pend_reg[gi]     <= pend_reg[gi-1];
        pend_idx_reg[gi] <= pend_idx_reg[gi-1];
      end
    end
  end

`ifdef LTL_MON_FIRST_HIT_EN
  logic             fh_vld_reg;
  logic [CNT_W-1:0] fh_idx_reg;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fh_vld_reg <= 1'b0;
      fh_idx_reg <= '0;
    end else if (start_ok) begin
      fh_vld_reg <= 1'b0;
      fh_idx_reg <= '0;
    end else if (sample_hit && !fh_vld_reg) begin
      fh_vld_reg <= 1'b1;
      fh_idx_reg <= pend_idx_reg[LAT-1];
    end
  end

  assign first_hit_vld = fh_vld_reg;
  assign first_hit_idx = fh_idx_reg;
`endif

  always_comb begin
    push_data       = '0;
    push_data.mask  = auto_reports;
    push_data.index = pend_idx_reg[LAT-1];
  end

  assign push = sample_hit;
  assign pop  = evt_ready & ~empty;

  ltl_mon_evt_fifo #(.DEPTH(EVT_DEPTH)) u_evt_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .push_data (push_data),
    .pop       (pop),
    .pop_data  (pop_data),
    .full      (full),
    .empty     (empty),
    .free_cnt  (free_cnt)
  );

  always_ff @(posedge clk) begin
    if (!reset) assert (!(push && full && !pop));
  end

  assign sym_ready      = ready_c;
  assign auto_run       = beat;
  assign auto_symbols   = sym_data;
  // During FLUSH the automaton leaves reset exactly on the first accepted beat.
  assign auto_reset     = (state_reg == ST_IDLE) | (state_reg == ST_FIN) |
                          ((state_reg == ST_FLUSH) & ~beat);
  assign evt_valid      = ~empty;
  assign evt_mask       = pop_data.mask;
  assign evt_index      = pop_data.index;
  assign sticky_reports = sticky_reg;
  assign busy           = (state_reg != ST_IDLE);
  assign done           = (state_reg == ST_FIN);

endmodule

// File: tb/tb_ltl_monitor_seq.sv
// Directed bench for ltl_monitor_seq with a small LUT-matcher automaton model driving auto_reports.
module tb_ltl_monitor_seq;

  logic        clk, reset, start, abort;
  logic        sym_valid, sym_last, sym_ready;
  logic [7:0]  sym_data, auto_symbols;
  logic        auto_run, auto_reset;
  logic [3:0]  auto_reports, evt_mask, sticky_reports;
  logic        evt_valid, evt_ready, busy, done;
  logic [31:0] evt_index;
`ifdef LTL_MON_FIRST_HIT_EN
  logic        first_hit_vld;
  logic [31:0] first_hit_idx;
`endif

  int passes = 0;
  int total  = 0;
  int done_cnt = 0;
  logic [3:0]  got_mask [$];
  logic [31:0] got_idx  [$];

  ltl_monitor_seq dut (
    .clk            (clk),
    .reset          (reset),
    .start          (start),
    .abort          (abort),
    .sym_valid      (sym_valid),
    .sym_data       (sym_data),
    .sym_last       (sym_last),
    .sym_ready      (sym_ready),
    .auto_run       (auto_run),
    .auto_reset     (auto_reset),
    .auto_symbols   (auto_symbols),
    .auto_reports   (auto_reports),
    .evt_valid      (evt_valid),
    .evt_ready      (evt_ready),
    .evt_mask       (evt_mask),
    .evt_index      (evt_index),
    .sticky_reports (sticky_reports),
`ifdef LTL_MON_FIRST_HIT_EN
    .first_hit_vld  (first_hit_vld),
    .first_hit_idx  (first_hit_idx),
`endif
    .busy           (busy),
    .done           (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Golden automaton: four LUT matchers, reports registered one cycle after a run beat.
  function automatic logic [3:0] golden(input logic [7:0] s);
    logic [3:0] r;
    r[0] = (s[7:4] == 4'h4);
    r[1] = s[0];
    r[2] = s[7];
    r[3] = (s == 8'h30);
    return r;
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset)           auto_reports <= 4'h0;
    else if (auto_reset) auto_reports <= 4'h0;
    else if (auto_run)   auto_reports <= golden(auto_symbols);
    else                 auto_reports <= 4'h0;
  end

  always @(posedge clk) begin
    if (!reset && evt_valid && evt_ready) begin
      got_mask.push_back(evt_mask);
      got_idx.push_back(evt_index);
      $display("evt pop: mask=%0h index=%0d", evt_mask, evt_index);
    end
    if (!reset && done) done_cnt++;
  end

  initial begin
    #50000;
    $display("FAIL watchdog: observed no finish, required finish before 50000");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Present one symbol, wait (bounded) for acceptance, then return at the next negedge.
  task automatic send(input logic [7:0] d, input logic last, output int waited, output logic rst_at);
    int n;
    sym_valid = 1'b1;
    sym_data  = d;
    sym_last  = last;
    n = 0;
    #1;
    while (!sym_ready && n < 50) begin
      @(negedge clk);
      #1;
      n++;
    end
    chk("beat_accept", sym_ready, 1);
    chk("beat_run", auto_run, 1);
    $display("beat: data=%02h last=%0b waited=%0d auto_reset=%0b", d, last, n, auto_reset);
    waited = n;
    rst_at = auto_reset;
    @(negedge clk);
    sym_valid = 1'b0;
    sym_last  = 1'b0;
  endtask

  int   w;
  logic r;
  int   acc;

  initial begin
    reset = 1'b1; start = 1'b0; abort = 1'b0;
    sym_valid = 1'b0; sym_data = 8'h00; sym_last = 1'b0; evt_ready = 1'b1;
    @(negedge clk);
    #1;
    chk("rst_auto_reset", auto_reset, 1);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_sym_ready", sym_ready, 0);
    chk("rst_evt_valid", evt_valid, 0);
    chk("rst_sticky", sticky_reports, 0);
    chk("rst_auto_run", auto_run, 0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    // 1) five-symbol trace, last on the fifth
    pulse_start();
    #1;
    chk("t1_flush_busy", busy, 1);
    chk("t1_flush_auto_reset", auto_reset, 1);
    send(8'h05, 1'b0, w, r);
    chk("t1_flush_wait", w, 2);
    chk("t1_reset_fall_on_beat", r, 0);
    send(8'h45, 1'b0, w, r);
    send(8'h20, 1'b0, w, r);
    send(8'h90, 1'b0, w, r);
    send(8'h30, 1'b1, w, r);
    #1;
    chk("t1_drain_busy", busy, 1);
    chk("t1_drain_done", done, 0);
    @(negedge clk); #1;
    chk("t1_fin_done", done, 1);
    chk("t1_fin_auto_reset", auto_reset, 1);
    @(negedge clk); #1;
    chk("t1_idle_done", done, 0);
    chk("t1_idle_busy", busy, 0);
    repeat (2) @(negedge clk);
    chk("t1_evt_count", got_mask.size(), 4);
    chk("t1_e0_mask", got_mask[0], 4'h2); chk("t1_e0_idx", got_idx[0], 0);
    chk("t1_e1_mask", got_mask[1], 4'h3); chk("t1_e1_idx", got_idx[1], 1);
    chk("t1_e2_mask", got_mask[2], 4'h4); chk("t1_e2_idx", got_idx[2], 3);
    chk("t1_e3_mask", got_mask[3], 4'h8); chk("t1_e3_idx", got_idx[3], 4);
    chk("t1_sticky", sticky_reports, 4'hF);
    chk("t1_done_pulses", done_cnt, 1);

    // 2) long idle gap after FLUSH
    got_mask.delete(); got_idx.delete();
    pulse_start();
    repeat (12) @(negedge clk);
    #1;
    chk("t2_gap_auto_reset", auto_reset, 1);
    send(8'h05, 1'b0, w, r);
    chk("t2_accept_immediate", w, 0);
    chk("t2_reset_fall_on_beat", r, 0);
    send(8'h45, 1'b1, w, r);
    repeat (4) @(negedge clk);
    chk("t2_evt_count", got_mask.size(), 2);
    chk("t2_e0_idx", got_idx[0], 0);
    chk("t2_e0_mask", got_mask[0], 4'h2);
    chk("t2_e1_idx", got_idx[1], 1);
    chk("t2_sticky", sticky_reports, 4'h3);

    // 3) consumer stalled, every symbol reports
    got_mask.delete(); got_idx.delete();
    evt_ready = 1'b0;
    pulse_start();
    sym_valid = 1'b1; sym_data = 8'h41; sym_last = 1'b0;
    acc = 0;
    for (int i = 0; i < 10; i++) begin
      #1;
      if (sym_ready) acc++;
      @(negedge clk);
    end
    chk("t3_beats_before_stall", acc, 4);
    #1;
    chk("t3_stalled_ready", sym_ready, 0);
    chk("t3_head_valid", evt_valid, 1);
    chk("t3_head_index", evt_index, 0);
    evt_ready = 1'b1;
    send(8'h41, 1'b1, w, r);
    chk("t3_resume_wait", w, 2);
    repeat (8) @(negedge clk);
    chk("t3_evt_count", got_mask.size(), 5);
    for (int i = 0; i < 5; i++) begin
      chk("t3_evt_idx", got_idx[i], 64'(i));
      chk("t3_evt_mask", got_mask[i], 4'h3);
    end

    // 4) abort three beats into the session
    got_mask.delete(); got_idx.delete();
    pulse_start();
    send(8'h05, 1'b0, w, r);
    send(8'h45, 1'b0, w, r);
    send(8'h45, 1'b0, w, r);
    sym_valid = 1'b1; sym_data = 8'h05; abort = 1'b1;
    #1;
    chk("t4_abort_ready", sym_ready, 0);
    chk("t4_abort_run", auto_run, 0);
    @(negedge clk);
    abort = 1'b0;
    #1;
    chk("t4_fin_done", done, 1);
    chk("t4_fin_auto_reset", auto_reset, 1);
    chk("t4_fin_ready", sym_ready, 0);
    @(negedge clk);
    sym_valid = 1'b0;
    #1;
    chk("t4_idle_busy", busy, 0);
    repeat (3) @(negedge clk);
    chk("t4_evt_count", got_mask.size(), 3);
    chk("t4_e2_idx", got_idx[2], 2);
    chk("t4_e2_mask", got_mask[2], 4'h3);

    // start and abort together in IDLE: stay idle
    start = 1'b1; abort = 1'b1;
    @(negedge clk);
    start = 1'b0; abort = 1'b0;
    #1;
    chk("idle_abort_wins", busy, 0);
    @(negedge clk);
    chk("done_total", done_cnt, 4);

`ifdef LTL_MON_FIRST_HIT_EN
    // 6) first hit on index 7, cleared by the next start
    pulse_start();
    #1;
    chk("t6_vld_cleared", first_hit_vld, 0);
    for (int i = 0; i < 7; i++) send(8'h20, 1'b0, w, r);
    send(8'h45, 1'b1, w, r);
    repeat (3) @(negedge clk);
    chk("t6_first_vld", first_hit_vld, 1);
    chk("t6_first_idx", first_hit_idx, 7);
    pulse_start();
    #1;
    chk("t6_restart_vld", first_hit_vld, 0);
    chk("t6_restart_idx", first_hit_idx, 0);
    @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    repeat (2) @(negedge clk);
`endif

    // 5) reset in the middle of RUN
    pulse_start();
    send(8'h05, 1'b0, w, r);
    send(8'h45, 1'b0, w, r);
    sym_valid = 1'b1; sym_data = 8'h20;
    #1;
    chk("t5_pre_run", auto_run, 1);
    chk("t5_pre_sticky", sticky_reports, 4'h2);
    #2;
    reset = 1'b1;
    #1;
    chk("t5_auto_reset", auto_reset, 1);
    chk("t5_busy", busy, 0);
    chk("t5_sym_ready", sym_ready, 0);
    chk("t5_auto_run", auto_run, 0);
    chk("t5_evt_valid", evt_valid, 0);
    chk("t5_sticky", sticky_reports, 0);
    chk("t5_done", done, 0);
    @(negedge clk);
    sym_valid = 1'b0;
    reset = 1'b0;
    @(negedge clk);

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule
